// File: rtl/dot_product_sequencer.sv
// Purpose : sequences one vector-vector dot product: streams NO_OF_UNITS-element words from the
//           A/B vector RAMs into the eight-lane datapath, waits for its finish strobe, then pulses done.
// Latency : first beat to datapath 2 cycles after start; done 1 cycle after dp_finish (len=0: done 2 cycles after start).
// Backpressure: none; start is ignored while busy, and the datapath must accept one word per cycle.
//
// Ports: clk/reset (sync, active-high); start/length/base_a/base_b request; busy/done/result status;
//        mem_re/mem_a_addr/mem_b_addr/mem_a_rdata/mem_b_rdata vector RAM side (1-cycle read latency);
//        dp_a/dp_b/dp_valid/dp_last/dp_finish/dp_result datapath side.
// Build option: define DOT_TAIL_MASK_EN to zero the lanes past the vector end on the final beat;
//               without it, the RAMs must hold zero padding up to the word boundary.
module dot_product_sequencer #(
    parameter int ELEMENT_WIDTH = 32,
    parameter int NO_OF_UNITS   = 8,
    parameter int NOE           = 10,
    parameter int ADDR_WIDTH    = 8,
    parameter int LEN_WIDTH     = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [LEN_WIDTH-1:0]                 length,
    input  logic [ADDR_WIDTH-1:0]                base_a,
    input  logic [ADDR_WIDTH-1:0]                base_b,
    output logic                                 busy,
    output logic                                 done,
    output logic [ELEMENT_WIDTH-1:0]             result,
    output logic                                 mem_re,
    output logic [ADDR_WIDTH-1:0]                mem_a_addr,
    output logic [ADDR_WIDTH-1:0]                mem_b_addr,
    input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] mem_a_rdata,
    input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] mem_b_rdata,
    output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] dp_a,
    output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] dp_b,
    output logic                                 dp_valid,
    output logic                                 dp_last,
    input  logic                                 dp_finish,
    input  logic [ELEMENT_WIDTH-1:0]             dp_result
);

    localparam logic [LEN_WIDTH-1:0]  NOE_L   = LEN_WIDTH'(NOE);
    localparam logic [LEN_WIDTH-1:0]  UNITS_L = LEN_WIDTH'(NO_OF_UNITS);
    localparam logic [LEN_WIDTH-1:0]  ONE_L   = LEN_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);

    // ZERO is the settle cycle for an empty vector so done lands two cycles after start.
    typedef enum logic [2:0] {IDLE, READ, WAIT, ZERO, DONE} state_t;

    state_t                 state, state_nxt;
    logic [LEN_WIDTH-1:0]   len_c;
    logic [LEN_WIDTH-1:0]   beats_c;
    logic [LEN_WIDTH-1:0]   beats_q;
    logic [LEN_WIDTH-1:0]   beat_cnt;
    logic [ADDR_WIDTH-1:0]  addr_a;
    logic [ADDR_WIDTH-1:0]  addr_b;
    logic                   last_issue;
`ifdef DOT_TAIL_MASK_EN
    logic [LEN_WIDTH-1:0]   tail_cnt;   // live lanes in the final word (1..NO_OF_UNITS)
`endif

    assign len_c      = (length > NOE_L) ? NOE_L : length;
    assign beats_c    = (len_c + UNITS_L - ONE_L) / UNITS_L;
    assign last_issue = (state == READ) && (beat_cnt == beats_q - ONE_L);

    assign mem_re     = (state == READ);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign mem_a_addr = addr_a;
    assign mem_b_addr = addr_b;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; dp_finish is only honoured in WAIT, so a strobe coincident
    // with the final read issue is dropped.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (len_c == '0) ? ZERO : READ;
            READ: if (last_issue) state_nxt = WAIT;
            WAIT: if (dp_finish) state_nxt = DONE;
            ZERO: state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture, address walk, beat flags and result register
    always_ff @(posedge clk) begin
        if (reset) begin
            beats_q  <= '0;
            beat_cnt <= '0;
            addr_a   <= '0;
            addr_b   <= '0;
            dp_valid <= 1'b0;
            dp_last  <= 1'b0;
            result   <= '0;
`ifdef DOT_TAIL_MASK_EN
            tail_cnt <= '0;
`endif
        end else begin
            // RAM data arrives one cycle after the read, aligned with these flags.
            dp_valid <= (state == READ);
            dp_last  <= last_issue;
            case (state)
                IDLE: begin
                    if (start) begin
                        beats_q  <= beats_c;
                        beat_cnt <= '0;
`ifdef DOT_TAIL_MASK_EN
                        tail_cnt <= len_c - (beats_c - ONE_L) * UNITS_L;
`endif
                        if (len_c != '0) begin
                            addr_a <= base_a;
                            addr_b <= base_b;
                        end else begin
                            result <= '0;
                        end
                    end
                end
                READ: begin
                    // Addresses stay on the last word once the burst ends.
                    if (!last_issue) begin
                        beat_cnt <= beat_cnt + ONE_L;
                        addr_a   <= addr_a + ONE_A;
                        addr_b   <= addr_b + ONE_A;
                    end
                end
                WAIT: begin
                    if (dp_finish) result <= dp_result;
                end
                default: ;
            endcase
        end
    end

    // Datapath operands: RAM read data, zero when no beat is valid.
    always_comb begin
        dp_a = '0;
        dp_b = '0;
        if (dp_valid) begin
            dp_a = mem_a_rdata;
            dp_b = mem_b_rdata;
`ifdef DOT_TAIL_MASK_EN
            if (dp_last) begin
                for (int i = 0; i < NO_OF_UNITS; i++) begin
                    if (LEN_WIDTH'(i) >= tail_cnt) begin
                        dp_a[i*ELEMENT_WIDTH +: ELEMENT_WIDTH] = '0;
                        dp_b[i*ELEMENT_WIDTH +: ELEMENT_WIDTH] = '0;
                    end
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_dot_product_sequencer.sv
module tb_dot_product_sequencer;

    localparam int EW = 32;
    localparam int NU = 8;
    localparam int DW = EW * NU;
`ifdef DOT_TAIL_MASK_EN
    localparam bit MASK = 1'b1;
`else
    localparam bit MASK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [15:0]   length = '0;
    logic [7:0]    base_a = '0;
    logic [7:0]    base_b = '0;
    logic          busy, done, mem_re, dp_valid, dp_last;
    logic [EW-1:0] result;
    logic [7:0]    mem_a_addr, mem_b_addr;
    logic [DW-1:0] mem_a_rdata = '0;
    logic [DW-1:0] mem_b_rdata = '0;
    logic [DW-1:0] dp_a, dp_b;
    logic          dp_finish = 1'b0;
    logic [EW-1:0] dp_result = '0;

    dot_product_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .length(length),
        .base_a(base_a), .base_b(base_b), .busy(busy), .done(done), .result(result),
        .mem_re(mem_re), .mem_a_addr(mem_a_addr), .mem_b_addr(mem_b_addr),
        .mem_a_rdata(mem_a_rdata), .mem_b_rdata(mem_b_rdata),
        .dp_a(dp_a), .dp_b(dp_b), .dp_valid(dp_valid), .dp_last(dp_last),
        .dp_finish(dp_finish), .dp_result(dp_result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Vector RAMs with one-cycle read latency
    logic [DW-1:0] mem_a [256];
    logic [DW-1:0] mem_b [256];
    always @(posedge clk) begin
        if (mem_re) begin
            mem_a_rdata <= mem_a[mem_a_addr];
            mem_b_rdata <= mem_b[mem_b_addr];
        end
    end

    // Observation logs
    int            rd_cyc[$];
    int            rd_a[$];
    int            rd_b[$];
    int            cap_cyc[$];
    logic [DW-1:0] cap_a[$];
    logic [DW-1:0] cap_b[$];
    bit            cap_last[$];
    int            done_cyc[$];
    logic [EW-1:0] done_res[$];
    bit            busy_hist [65536];

    // Datapath model: finish strobe fin_lat cycles after the dp_last beat
    int            fin_lat = 1;
    logic [EW-1:0] fin_res = '0;
    int            cd = 0;

    always @(negedge clk) begin
        busy_hist[cyc & 16'hFFFF] = busy;
        if (mem_re) begin
            rd_cyc.push_back(cyc); rd_a.push_back(int'(mem_a_addr)); rd_b.push_back(int'(mem_b_addr));
        end
        if (dp_valid) begin
            cap_cyc.push_back(cyc); cap_a.push_back(dp_a); cap_b.push_back(dp_b); cap_last.push_back(dp_last);
        end
        if (done) begin
            done_cyc.push_back(cyc); done_res.push_back(result);
        end
        dp_finish = 1'b0;
        dp_result = 32'hDEADBEEF;
        if (reset) begin
            cd = 0;
        end else begin
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    dp_finish = 1'b1;
                    dp_result = fin_res;
                end
            end
            if (dp_valid && dp_last) cd = fin_lat;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic clear_logs();
        rd_cyc.delete(); rd_a.delete(); rd_b.delete();
        cap_cyc.delete(); cap_a.delete(); cap_b.delete(); cap_last.delete();
        done_cyc.delete(); done_res.delete();
    endtask

    task automatic fill_const(input logic [EW-1:0] v);
        for (int w = 0; w < 256; w++)
            for (int l = 0; l < NU; l++) begin
                mem_a[w][l*EW +: EW] = v;
                mem_b[w][l*EW +: EW] = v;
            end
    endtask

    task automatic fill_rand();
        for (int w = 0; w < 256; w++)
            for (int l = 0; l < NU; l++) begin
                mem_a[w][l*EW +: EW] = $urandom;
                mem_b[w][l*EW +: EW] = $urandom;
            end
    endtask

    // Expected operand word: RAM word, lanes beyond the vector end zeroed on the final beat if masking.
    function automatic logic [DW-1:0] exp_word(input logic [DW-1:0] w, input int k, input int lenc, input bit last);
        logic [DW-1:0] r;
        r = w;
        if (MASK && last)
            for (int i = 0; i < NU; i++)
                if (k * NU + i >= lenc) r[i*EW +: EW] = '0;
        return r;
    endfunction

    task automatic run_txn(input int len, input int ba, input int bb, input int lat,
                           input logic [EW-1:0] res, input int beats, input int off, input bit restart);
        int t0, lenc, d;
        logic [EW-1:0] exp_res;
        lenc    = (len > 10) ? 10 : len;
        exp_res = (lenc == 0) ? '0 : res;
        clear_logs();
        fin_lat = lat;
        fin_res = res;
        @(negedge clk);
        start = 1'b1; length = 16'(len); base_a = 8'(ba); base_b = 8'(bb);
        t0 = cyc;
        for (int w = 0; w < 300; w++) begin
            @(negedge clk);
            start  = restart && (cyc == t0 + beats + 2);
            length = 16'd5;
            if (done_cyc.size() > 0) break;
        end
        start = 1'b0;
        repeat (20) @(negedge clk);

        chk("done_count", 256'(done_cyc.size()), 256'd1);
        if (done_cyc.size() > 0) begin
            d = done_cyc[0];
            chk("done_cycle", 256'(d - t0), 256'(off));
            chk("done_result", 256'(done_res[0]), 256'(exp_res));
            chk("result_held", 256'(result), 256'(exp_res));
            chk("busy_at_done", 256'(busy_hist[d & 16'hFFFF]), 256'd1);
            chk("busy_after_done", 256'(busy_hist[(d + 1) & 16'hFFFF]), 256'd0);
        end
        chk("busy_after_start", 256'(busy_hist[(t0 + 1) & 16'hFFFF]), 256'd1);
        chk("read_count", 256'(rd_cyc.size()), 256'(beats));
        chk("beat_count", 256'(cap_cyc.size()), 256'(beats));
        for (int k = 0; k < beats; k++) begin
            if (k < rd_cyc.size()) begin
                chk("read_cycle", 256'(rd_cyc[k] - t0), 256'(1 + k));
                chk("addr_a", 256'(rd_a[k]), 256'((ba + k) % 256));
                chk("addr_b", 256'(rd_b[k]), 256'((bb + k) % 256));
            end
            if (k < cap_cyc.size()) begin
                chk("beat_cycle", 256'(cap_cyc[k] - t0), 256'(2 + k));
                chk("beat_last", 256'(cap_last[k]), 256'(k == beats - 1));
                chk("dp_a", cap_a[k], exp_word(mem_a[(ba + k) % 256], k, lenc, k == beats - 1));
                chk("dp_b", cap_b[k], exp_word(mem_b[(bb + k) % 256], k, lenc, k == beats - 1));
            end
        end
    endtask

    typedef struct {
        int          len;
        int          ba;
        int          bb;
        int          lat;
        logic [31:0] res;
        int          beats;
        int          off;
        bit          restart;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int t0, len, lenc, beats, lat;
        tbl[0] = '{8,    0,    4,    5, 32'h41200000, 1, 8, 1'b0};
        tbl[1] = '{10,   16,   32,   5, 32'h3F800000, 2, 9, 1'b0};
        tbl[2] = '{0,    3,    7,    5, 32'h12345678, 0, 2, 1'b0};
        tbl[3] = '{10,   48,   64,   4, 32'h40000000, 2, 8, 1'b1};
        tbl[4] = '{16,   1,    2,    3, 32'hC0A00000, 2, 7, 1'b0};
        tbl[5] = '{9,    255,  254,  1, 32'h3E800000, 2, 5, 1'b0};
        tbl[6] = '{1,    9,    9,    2, 32'h7F7FFFFF, 1, 5, 1'b0};

        fill_const(32'h3F800000);
        repeat (3) @(negedge clk);
        chk("rst_busy", 256'(busy), 256'd0);
        chk("rst_done", 256'(done), 256'd0);
        chk("rst_result", 256'(result), 256'd0);
        chk("rst_mem_re", 256'(mem_re), 256'd0);
        chk("rst_addr", 256'({mem_a_addr, mem_b_addr}), 256'd0);
        chk("rst_dp_flags", 256'({dp_valid, dp_last}), 256'd0);
        chk("rst_dp_a", dp_a, '0);
        chk("rst_dp_b", dp_b, '0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            if (i == 4) fill_rand();
            run_txn(tbl[i].len, tbl[i].ba, tbl[i].bb, tbl[i].lat, tbl[i].res,
                    tbl[i].beats, tbl[i].off, tbl[i].restart);
        end

        // Reset during READ of a long request
        clear_logs();
        @(negedge clk);
        start = 1'b1; length = 16'd24; base_a = 8'd10; base_b = 8'd20;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        chk("abort_mem_re_before", 256'(mem_re), 256'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_mem_re", 256'(mem_re), 256'd0);
        chk("abort_dp_valid", 256'(dp_valid), 256'd0);
        chk("abort_dp_a", dp_a, '0);
        chk("abort_busy", 256'(busy), 256'd0);
        chk("abort_result", 256'(result), 256'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_no_done", 256'(done_cyc.size()), 256'd0);
        chk("abort_beats", 256'(cap_cyc.size()), 256'd0);
        run_txn(8, 0, 4, 5, 32'h41200000, 1, 8, 1'b0);

        // Randomized requests checked against the arithmetic model
        for (int r = 0; r < 20; r++) begin
            fill_rand();
            len   = $urandom_range(0, 20);
            lat   = $urandom_range(1, 6);
            lenc  = (len > 10) ? 10 : len;
            beats = (lenc + NU - 1) / NU;
            run_txn(len, $urandom_range(0, 255), $urandom_range(0, 255), lat, $urandom,
                    beats, (lenc == 0) ? 2 : beats + lat + 2, $urandom_range(0, 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
